// File: rtl/unified_mem_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and data access.
// Data has priority; a streak guard bounds how long a fetch can starve.
module unified_mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      imem_addr,
   input  logic             imem_ena,
   output logic             imem_gnt,
   output logic             imem_rvalid,
   output logic [31:0]      imem_rdata,
   input  logic [31:0]      dmem_addr,
   input  logic [31:0]      dmem_wdata,
   input  logic [3:0]       dmem_wen,
   input  logic             dmem_ena,
   output logic             dmem_gnt,
   output logic             dmem_rvalid,
   output logic [31:0]      dmem_rdata,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_dout,
   input  logic [31:0]      mem_din,
   output logic             mem_ena,
   output logic [3:0]       mem_wen,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      RSP_NONE = 2'd0,
      RSP_IMEM = 2'd1,
      RSP_DMEM = 2'd2
   } rsp_t;

   rsp_t          rsp;
   rsp_t          rsp_nxt;
   logic [SW-1:0] streak;
   logic [SW-1:0] streak_nxt;
   logic          starve;
   logic          d_rd;
   logic [31:0]   imem_hold;
   logic [31:0]   dmem_hold;

   assign starve   = (STARVE_LIMIT > 0) && (streak == LIM);
   assign dmem_gnt = dmem_ena & ~(imem_ena & starve);
   assign imem_gnt = imem_ena & ~dmem_gnt;
   assign mem_ena  = imem_gnt | dmem_gnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rsp <= RSP_NONE;
      else       rsp <= rsp_nxt;
   end

   always_comb begin
      rsp_nxt  = RSP_NONE;
      mem_addr = '0;
      mem_dout = '0;
      mem_wen  = '0;
      unique case (1'b1)
         dmem_gnt: begin
            rsp_nxt  = RSP_DMEM;
            mem_addr = dmem_addr;
            mem_dout = dmem_wdata;
            mem_wen  = dmem_wen;
         end
         imem_gnt: begin
            rsp_nxt  = RSP_IMEM;
            mem_addr = imem_addr;
         end
         default: ;
      endcase
   end

   // Streak only counts data wins that actually blocked a pending fetch.
   always_comb begin
      streak_nxt = streak;
      if (imem_gnt || !imem_ena)
         streak_nxt = '0;
      else if (dmem_gnt && streak != LIM)
         streak_nxt = streak + 1'b1;
   end

   assign imem_rvalid = (rsp == RSP_IMEM);
   assign dmem_rvalid = (rsp == RSP_DMEM);
   assign imem_rdata  = imem_rvalid ? mem_din : imem_hold;
   assign dmem_rdata  = (dmem_rvalid && d_rd) ? mem_din : dmem_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak    <= '0;
         d_rd      <= 1'b0;
         imem_hold <= '0;
         dmem_hold <= '0;
         stall_cnt <= '0;
      end else begin
         streak <= streak_nxt;
         if (dmem_gnt)
            d_rd <= (dmem_wen == 4'b0);
         if (imem_rvalid)
            imem_hold <= mem_din;
         if (dmem_rvalid && d_rd)
            dmem_hold <= mem_din;
         if (imem_ena && !imem_gnt && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural 1-cycle RAM.
// A second instance covers pure data priority and a narrow counter.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata;
   logic        imem_ena, dmem_ena;
   logic [3:0]  dmem_wen;
   logic        imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid;
   logic [31:0] imem_rdata, dmem_rdata;
   logic [31:0] mem_addr, mem_dout, mem_din;
   logic        mem_ena;
   logic [3:0]  mem_wen;
   logic [31:0] stall_cnt;

   logic        imem_ena1, dmem_ena1;
   logic        imem_gnt1, imem_rvalid1, dmem_gnt1, dmem_rvalid1;
   logic [31:0] imem_rdata1, dmem_rdata1;
   logic [31:0] mem_addr1, mem_dout1;
   logic [31:0] mem_din1;
   logic        mem_ena1;
   logic [3:0]  mem_wen1;
   logic [3:0]  stall_cnt1;

   logic [31:0] ram [0:255];

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_ena(imem_ena),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wen(dmem_wen), .dmem_ena(dmem_ena),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata),
      .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ena(mem_ena),
      .mem_wen(mem_wen), .stall_cnt(stall_cnt)
   );

   unified_mem_arbiter #(.STARVE_LIMIT(0), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset),
      .imem_addr(32'h0000_0040), .imem_ena(imem_ena1),
      .imem_gnt(imem_gnt1), .imem_rvalid(imem_rvalid1),
      .imem_rdata(imem_rdata1),
      .dmem_addr(32'h0000_0080), .dmem_wdata(32'h0),
      .dmem_wen(4'h0), .dmem_ena(dmem_ena1),
      .dmem_gnt(dmem_gnt1), .dmem_rvalid(dmem_rvalid1),
      .dmem_rdata(dmem_rdata1),
      .mem_addr(mem_addr1), .mem_dout(mem_dout1),
      .mem_din(mem_din1), .mem_ena(mem_ena1),
      .mem_wen(mem_wen1), .stall_cnt(stall_cnt1)
   );

   always @(posedge clk) begin
      if (mem_ena) begin
         for (int b = 0; b < 4; b++)
            if (mem_wen[b])
               ram[mem_addr[9:2]][b*8 +: 8] <= mem_dout[b*8 +: 8];
         mem_din <= ram[mem_addr[9:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] fdat [0:2];
      fdat[0] = 32'h11;
      fdat[1] = 32'h22;
      fdat[2] = 32'h33;
      for (int k = 0; k < 256; k++) ram[k] <= 32'h0;
      ram[0]   <= 32'h11;
      ram[1]   <= 32'h22;
      ram[2]   <= 32'h33;
      ram[128] <= 32'h1234_5678;
      mem_din1   = 32'h0;
      reset      = 1'b1;
      imem_ena   = 1'b0;
      dmem_ena   = 1'b0;
      imem_addr  = 32'h0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      dmem_wen   = 4'h0;
      imem_ena1  = 1'b0;
      dmem_ena1  = 1'b0;

      @(negedge clk);
      chk("rst_irv",   32'(imem_rvalid), 32'd0);
      chk("rst_drv",   32'(dmem_rvalid), 32'd0);
      chk("rst_ird",   imem_rdata, 32'h0);
      chk("rst_drd",   dmem_rdata, 32'h0);
      chk("rst_stall", stall_cnt, 32'h0);
      chk("rst_mena",  32'(mem_ena), 32'd0);
      chk("rst_maddr", mem_addr, 32'h0);
      chk("rst_gnts",  32'({imem_gnt, dmem_gnt}), 32'd0);

      // fetch-only stream
      cyc();
      reset     = 1'b0;
      imem_ena  = 1'b1;
      imem_addr = 32'h0;
      @(negedge clk);
      chk("f0_gnt",  32'(imem_gnt), 32'd1);
      chk("f0_addr", mem_addr, 32'h0);
      chk("f0_wen",  32'(mem_wen), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         cyc();
         if (k < 3) imem_addr = 32'(4 * k);
         else       imem_ena  = 1'b0;
         @(negedge clk);
         chk("f_rv", 32'(imem_rvalid), 32'd1);
         chk("f_rd", imem_rdata, fdat[k-1]);
         if (k < 3) chk("f_gnt", 32'(imem_gnt), 32'd1);
      end
      cyc();
      @(negedge clk);
      chk("f_rv_end",  32'(imem_rvalid), 32'd0);
      chk("f_hold",    imem_rdata, 32'h33);
      chk("f_stall",   stall_cnt, 32'h0);

      // contention with STARVE_LIMIT=4
      cyc();
      imem_ena  = 1'b1;
      imem_addr = 32'h8;
      dmem_ena  = 1'b1;
      dmem_addr = 32'h300;
      dmem_wen  = 4'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("starve_gnt", 32'({imem_gnt, dmem_gnt}),
             (i == 4 || i == 9) ? 32'd2 : 32'd1);
         cyc();
      end
      imem_ena = 1'b0;
      dmem_ena = 1'b0;
      @(negedge clk);
      chk("starve_stall", stall_cnt, 32'd8);

      // full-word store then load
      cyc();
      dmem_ena   = 1'b1;
      dmem_addr  = 32'h100;
      dmem_wdata = 32'hDEAD_BEEF;
      dmem_wen   = 4'hF;
      @(negedge clk);
      chk("st_gnt",  32'(dmem_gnt), 32'd1);
      chk("st_wen",  32'(mem_wen), 32'hF);
      chk("st_dout", mem_dout, 32'hDEAD_BEEF);
      cyc();
      dmem_wen = 4'h0;
      @(negedge clk);
      chk("st_ack",  32'(dmem_rvalid), 32'd1);
      chk("st_rd",   dmem_rdata, 32'h0);
      chk("ld_gnt",  32'(dmem_gnt), 32'd1);
      cyc();
      dmem_ena = 1'b0;
      @(negedge clk);
      chk("ld_rv", 32'(dmem_rvalid), 32'd1);
      chk("ld_rd", dmem_rdata, 32'hDEAD_BEEF);

      // byte-lane store
      cyc();
      dmem_ena   = 1'b1;
      dmem_addr  = 32'h200;
      dmem_wdata = 32'h0000_AB00;
      dmem_wen   = 4'h2;
      @(negedge clk);
      chk("bst_wen", 32'(mem_wen), 32'h2);
      cyc();
      dmem_wen = 4'h0;
      cyc();
      dmem_ena = 1'b0;
      @(negedge clk);
      chk("bld_rd", dmem_rdata, 32'h1234_AB78);
      cyc();
      @(negedge clk);
      chk("bld_rv0",  32'(dmem_rvalid), 32'd0);
      chk("bld_hold", dmem_rdata, 32'h1234_AB78);

      // asynchronous reset with a fetch outstanding
      cyc();
      imem_ena  = 1'b1;
      imem_addr = 32'h0;
      @(negedge clk);
      chk("ar_gnt", 32'(imem_gnt), 32'd1);
      #1;
      reset    = 1'b1;
      imem_ena = 1'b0;
      #1;
      reset = 1'b0;
      cyc();
      @(negedge clk);
      chk("ar_rv",    32'(imem_rvalid), 32'd0);
      chk("ar_ird",   imem_rdata, 32'h0);
      chk("ar_drd",   dmem_rdata, 32'h0);
      chk("ar_stall", stall_cnt, 32'h0);

      // pure data priority, 4-bit counter
      cyc();
      imem_ena1 = 1'b1;
      dmem_ena1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("pd_igtn", 32'(imem_gnt1), 32'd0);
         cyc();
      end
      imem_ena1 = 1'b0;
      dmem_ena1 = 1'b0;
      @(negedge clk);
      chk("pd_stall", 32'(stall_cnt1), 32'd15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
